// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM transactions (low half, then high half).
// ready is low from the request cycle through the access; SRAM_ADDR_CHECK_EN adds out-of-range rejection with addr_err.
module sram_mem_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_ADDR_CHECK_EN
  , output logic      addr_err
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [16:0] word_idx;
  logic        req;
  logic        last;
  logic        bad;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req      = wr_en | rd_en;
  assign last     = (wait_cnt == LAST_CNT);
  assign word_idx = 17'((addr_q - BASE_ADDR) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  logic [31:0] in_off;
  assign in_off = address - BASE_ADDR;
  assign bad    = (address < BASE_ADDR) || (in_off >= 32'h0008_0000) || (address[1:0] != 2'b00);
`else
  assign bad    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = bad ? DONE : LOW;
      LOW:     if (last) state_nxt = HIGH;
      HIGH:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 4'd0;
      op_wr     <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      read_data <= 32'd0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      if (state_nxt != state)                 wait_cnt <= 4'd0;
      else if (state == LOW || state == HIGH) wait_cnt <= wait_cnt + 4'd1;
      else                                    wait_cnt <= 4'd0;

      if (state == IDLE && req) begin
        op_wr  <= wr_en;
        addr_q <= address;
        data_q <= write_data;
      end

      // each half is sampled at the end of its final hold cycle
      if (state == LOW && last && !op_wr)  read_data[15:0]  <= SRAM_DQ;
      if (state == HIGH && last && !op_wr) read_data[31:16] <= SRAM_DQ;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err <= (state == IDLE) && req && bad;
      if (state == IDLE && req && bad && !wr_en) read_data <= 32'd0;
`endif
    end
  end

  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = 18'd0;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    if (state == LOW || state == HIGH) begin
      SRAM_ADDR = {word_idx, state == HIGH};
      if (op_wr) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = (state == HIGH) ? data_q[31:16] : data_q[15:0];
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign ready     = ((state == IDLE) && !req) || (state == DONE);
  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
